// File: rtl/digit_serial_add_sub.sv
// Digit-serial two's-complement add/subtract, LSB digit first, with carry/overflow flags at word end.
// Latency 1 cycle (registered outputs); no backpressure, the sink takes every o_out_valid cycle.
module digit_serial_add_sub #(
  parameter int DIGIT_W     = 1,
  parameter int WORD_DIGITS = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_in_valid,
  input  logic               i_in_first,
  input  logic               i_sub,
  input  logic [DIGIT_W-1:0] i_a,
  input  logic [DIGIT_W-1:0] i_b,
  output logic               o_out_valid,
  output logic [DIGIT_W-1:0] o_out_sum,
  output logic               o_out_last,
  output logic               o_out_carry,
  output logic               o_out_overflow
);

  localparam int CW = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
  localparam logic [0:0]    S_IDLE   = 1'b0;
  localparam logic [0:0]    S_ACTIVE = 1'b1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WORD_DIGITS - 1);

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_carry;
  logic          r_sub;

  logic               w_accept;
  logic               w_sub;
  logic               w_cin;
  logic [CW-1:0]      w_idx;
  logic               w_last;
  logic [DIGIT_W-1:0] w_b_eff;
  logic [DIGIT_W:0]   w_full;
  logic [DIGIT_W-1:0] w_s;
  logic               w_cout;
  logic               w_c_msb;

  // A framing digit always restarts a word, even mid-word (abort).
  assign w_accept = i_in_valid & (i_in_first | (r_state == S_ACTIVE));
  assign w_sub    = i_in_first ? i_sub : r_sub;
  assign w_cin    = i_in_first ? i_sub : r_carry;
  assign w_idx    = i_in_first ? '0 : r_cnt;
  assign w_last   = (w_idx == LAST_IDX);
  assign w_b_eff  = w_sub ? ~i_b : i_b;
  assign w_full   = {1'b0, i_a} + {1'b0, w_b_eff} + (DIGIT_W+1)'(w_cin);
  assign w_s      = w_full[DIGIT_W-1:0];
  assign w_cout   = w_full[DIGIT_W];
  // Carry into the top bit recovered from the sum bit and its two addend bits.
  assign w_c_msb  = w_s[DIGIT_W-1] ^ i_a[DIGIT_W-1] ^ w_b_eff[DIGIT_W-1];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_carry        <= 1'b0;
      r_sub          <= 1'b0;
      o_out_valid    <= 1'b0;
      o_out_sum      <= '0;
      o_out_last     <= 1'b0;
      o_out_carry    <= 1'b0;
      o_out_overflow <= 1'b0;
    end else begin
      o_out_valid <= w_accept;
      if (w_accept) begin
        o_out_sum      <= w_s;
        o_out_last     <= w_last;
        o_out_carry    <= w_last & w_cout;
        o_out_overflow <= w_last & (w_c_msb ^ w_cout);
        r_carry        <= w_cout;
        r_sub          <= w_sub;
        if (w_last) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end else begin
          r_state <= S_ACTIVE;
          r_cnt   <= w_idx + CW'(1);
        end
      end
    end
  end

endmodule
